// File: rtl/demux16.sv
// ============================================================================
//  Module   : demux16
//  Purpose  : Registered 1-to-2 word demultiplexer; each destination has its
//             own 2-entry FIFO draining over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,

    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,

    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready,

    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    localparam logic [1:0] c_OCC_FULL  = 2'd2;
    localparam logic [1:0] c_OCC_EMPTY = 2'd0;

    // Per-channel views, indexed by channel number
    logic [1:0]       w_out_ready;
    logic [1:0]       w_out_valid;
    logic [WIDTH-1:0] w_out_data [2];
    logic [1:0]       w_occ      [2];
    logic [7:0]       w_cnt      [2];

    assign w_out_ready[0] = out0_ready;
    assign w_out_ready[1] = out1_ready;

    // Acceptance looks only at registered occupancy: a full buffer refuses
    // even when its consumer is popping in the same cycle.
    assign in_ready = in_sel ? (w_occ[1] != c_OCC_FULL)
                             : (w_occ[0] != c_OCC_FULL);

    genvar c;
    generate
        for (c = 0; c < 2; c = c + 1) begin : g_chan
            localparam logic c_CH_SEL = 1'(c);

            logic [1:0]       r_occ;
            logic             r_wptr;
            logic             r_rptr;
            logic [7:0]       r_cnt;
            logic [WIDTH-1:0] r_mem [DEPTH];

            logic             w_push;
            logic             w_pop;
            logic             w_valid;

            assign w_valid = (r_occ != c_OCC_EMPTY);
            assign w_push  = in_valid & in_ready & (in_sel == c_CH_SEL);
            assign w_pop   = w_valid & w_out_ready[c];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_occ  <= 2'd0;
                    r_wptr <= 1'b0;
                    r_rptr <= 1'b0;
                    r_cnt  <= 8'd0;
                end else begin
                    if (w_push) begin
                        r_wptr <= ~r_wptr;
                    end
                    if (w_pop) begin
                        r_rptr <= ~r_rptr;
                        r_cnt  <= r_cnt + 8'd1;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_occ <= r_occ + 2'd1;
                        2'b01:   r_occ <= r_occ - 2'd1;
                        default: r_occ <= r_occ;
                    endcase
                end
            end

            // Storage needs no reset; occupancy alone decides what is valid.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wptr] <= in_data;
                end
            end

            assign w_out_valid[c] = w_valid;
            assign w_out_data[c]  = w_valid ? r_mem[r_rptr] : '0;
            assign w_occ[c]       = r_occ;
            assign w_cnt[c]       = r_cnt;
        end
    endgenerate

    assign out0_valid = w_out_valid[0];
    assign out0_data  = w_out_data[0];
    assign out1_valid = w_out_valid[1];
    assign out1_data  = w_out_data[1];
    assign cnt0       = w_cnt[0];
    assign cnt1       = w_cnt[1];

endmodule

`default_nettype wire

// File: doc/demux16.md
# demux16

Registered 1-to-2 demultiplexer for 16-bit words, the counterpart of the datapath's 2:1 16-bit select. A single producer hands one word per cycle to the block. Each word is steered by `in_sel` into one of two independent 2-entry buffers, and each buffer drains to its own consumer over a valid/ready handshake. The block sits between a result source (ALU/load path) and two destinations (e.g. register-file write port and store/forward path), decoupling their stall behaviour.

## Interface
- `WIDTH`, default 16: data word width.
- `DEPTH`, default 2: entries per destination buffer. Fixed at 2; other values are unsupported.
- `clk` input, 1 bit: sole clock. All state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: producer offers a word this cycle.
- `in_sel` input, 1 bit: destination of the offered word (0 → channel 0, 1 → channel 1).
- `in_data` input, WIDTH bits: offered word.
- `in_ready` output, 1 bit: block accepts the offered word this cycle.
- `out0_valid` output, 1 bit: channel 0 head word is valid.
- `out0_data` output, WIDTH bits: channel 0 head word.
- `out0_ready` input, 1 bit: channel 0 consumer takes the head word.
- `out1_valid` output, 1 bit: channel 1 head word is valid.
- `out1_data` output, WIDTH bits: channel 1 head word.
- `out1_ready` input, 1 bit: channel 1 consumer takes the head word.
- `cnt0` output, 8 bits: channel 0 delivered-word counter.
- `cnt1` output, 8 bits: channel 1 delivered-word counter.

## Operation
- Each channel has a 2-entry circular FIFO with a 2-bit occupancy (0..2), a write pointer and a read pointer.
- `in_ready` is combinational: it equals `in_sel ? (occ1 != 2) : (occ0 != 2)`. It depends only on registered occupancy and `in_sel`, never on `outX_ready`.
- **Push.** An input handshake (`in_valid & in_ready`) writes `in_data` into the buffer selected by `in_sel` and increments that buffer's occupancy. The unselected buffer is untouched.
- **Pop.** An output handshake on channel X (`outX_valid & outX_ready`) advances the read pointer of X and decrements its occupancy.
- **Simultaneous push and pop on the same channel.** Occupancy is unchanged, and both pointers advance.
- **Full buffer.** When the buffer is full, the push is refused for that cycle even if the same channel pops in that cycle. There is no pass-through on full.
- `outX_valid` is `occX != 0`.
- `outX_data` is the entry at the read pointer when `occX != 0`, and 16'h0000 when empty.
- **Ordering.** Words are delivered in acceptance order within a channel. There is no ordering guarantee across channels.
- **Counters.** `cntX` increments by 1 on every channel X output handshake. It is 8-bit unsigned and wraps from 255 to 0.
- `in_valid=0` causes no state change on the input side, regardless of `in_sel`.
- **Reset.** When `rst=1` at a clock edge:
  - both occupancies, all pointers and both counters clear to 0;
  - buffer contents are don't-care;
  - any push or pop in that same cycle is discarded.
- Reset has priority over all other activity, including reset asserted mid-stream.

## Timing
- **Values after reset:**
  - `out0_valid` = `out1_valid` = 0;
  - `out0_data` = `out1_data` = 16'h0000;
  - `cnt0` = `cnt1` = 0;
  - `in_ready` = 1 for either `in_sel` value.
- **Latency.** A word accepted at edge N is visible on `outX_data` with `outX_valid=1` in the cycle after edge N. Minimum latency is 1 cycle and there is no combinational input→output path.
- **Throughput.** 1 word/cycle into either channel, provided that channel's consumer keeps `outX_ready=1`.
- **Stalls.** With `outX_ready` held low, channel X accepts exactly 2 words, then deasserts `in_ready` for `in_sel=X`. The other channel continues to accept.
- `outX_valid` and `outX_data` are stable while `outX_ready=0`: no word is dropped or changed until it is taken.
- All outputs except `in_ready` are registered or derived from registered state only.

## Test plan
- **Reset values and basic routing.** Check the reset values listed in Timing. Then push 16'hA5A5 with `in_sel=0` and 16'h5A5A with `in_sel=1` on consecutive cycles, both ready lines high. Required: `out0_data`=A5A5 one cycle after its accept, `out1_data`=5A5A one cycle after its accept, `cnt0`=`cnt1`=1.
- **Backpressure and fill.** Hold `out0_ready=0` and push 1, 2, 3 to channel 0. Required: 1 and 2 accepted; `in_ready`=0 for the third word while `in_sel=0`; `in_ready`=1 with `in_sel=1`. Release `out0_ready`. Required: 1 then 2 delivered in order, then 3 accepted.
- **Full plus simultaneous pop.** Fill channel 1, then in one cycle assert `out1_ready=1` and push to channel 1. Required: push refused, one pop occurs, occupancy becomes 1. The next cycle's push is accepted.
- **Streaming throughput.** Push 0x0000..0x00FF alternating channels every cycle, both ready lines held high. Required: every word delivered exactly once, in order per channel, each one cycle after acceptance. `cnt0`=`cnt1`=128 afterwards.
- **Counter wrap.** Deliver 257 words on channel 0. Required: `cnt0` reads 255, then 0, then 1.
- **Reset mid-operation.** Assert `rst` for one cycle with both buffers holding 2 words and a push and a pop pending. Required: the next cycle shows both valids 0, both datas 0, counters 0, `in_ready`=1, and no stale word is ever delivered.
